// File: rtl/tiny1_uart_mmio_if.sv
// Bundle of the tiny1 mmap bus, IRQ pins and buart byte interface seen by tiny1_uart_mmio.
// master = core/buart side, slave = the UART controller.
interface tiny1_uart_mmio_if;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  logic          sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wr;
  logic          rd;
  logic [DW-1:0] rdata;
  logic          irq;
  logic          irqack;
  logic [BW-1:0] uart_din;
  logic          uart_valid;
  logic          uart_ready;
  logic          uart_rd;
  logic          uart_wr;
  logic [BW-1:0] uart_dout;

  modport master (
    output sel, addr, wdata, wr, rd, irqack, uart_din, uart_valid, uart_ready,
    input  rdata, irq, uart_rd, uart_wr, uart_dout
  );

  modport slave (
    input  sel, addr, wdata, wr, rd, irqack, uart_din, uart_valid, uart_ready,
    output rdata, irq, uart_rd, uart_wr, uart_dout
  );
endinterface

// File: rtl/tiny1_uart_mmio.sv
// Memory-mapped UART controller: RX/TX byte FIFOs between the tiny1 mmap window and buart,
// with buart strobe sequencing and a level IRQ that can be acknowledged.
module tiny1_uart_mmio #(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  tiny1_uart_mmio_if.slave  bus
);
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 16;
  localparam int unsigned BW    = 8;
  localparam int unsigned RX_PW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_PW + 1;
  localparam int unsigned TX_PW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_PW + 1;

  localparam logic [AW-1:0] A_STATUS = AW'('h0);
  localparam logic [AW-1:0] A_RXDATA = AW'('h2);
  localparam logic [AW-1:0] A_TXDATA = AW'('h4);
  localparam logic [AW-1:0] A_IRQEN  = AW'('h6);

  typedef enum logic {R_IDLE, R_HOLD} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_e;

  logic [BW-1:0]    rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_wp, rx_rp;
  logic [RX_CW-1:0] rx_cnt;
  logic [BW-1:0]    tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_wp, tx_rp;
  logic [TX_CW-1:0] tx_cnt;

  rx_state_e rx_state, rx_next;
  tx_state_e tx_state, tx_next;

  logic          rx_go, tx_go;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_pop, tx_wr, tx_push, status_wr, irqen_wr;
  logic          tx_ovf;
  logic [1:0]    irqen;
  logic          ack_hold, ack_hold_nxt, irq_cond;
  logic [DW-1:0] rdata_nxt;
  logic          unused_wdata;

  assign unused_wdata = ^bus.wdata[15:8];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_CW'(TX_DEPTH));

  // Bus-side decode; every decision below uses the pre-cycle FIFO state.
  assign rx_pop    = bus.sel && bus.rd && (bus.addr == A_RXDATA) && !rx_empty;
  assign tx_wr     = bus.sel && bus.wr && (bus.addr == A_TXDATA);
  assign tx_push   = tx_wr && !tx_full;
  assign status_wr = bus.sel && bus.wr && (bus.addr == A_STATUS);
  assign irqen_wr  = bus.sel && bus.wr && (bus.addr == A_IRQEN);

  // RX engine
  always_ff @(posedge clk) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE:  if (rx_go) rx_next = R_HOLD;
      R_HOLD:  rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    rx_go = 1'b0;
    if (rx_state == R_IDLE && bus.uart_valid && !rx_full) rx_go = 1'b1;
  end

  // TX engine
  always_ff @(posedge clk) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      T_IDLE:  if (tx_go) tx_next = T_SEND;
      T_SEND:  tx_next = T_WAIT;
      T_WAIT:  tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    tx_go = 1'b0;
    if (tx_state == T_IDLE && !tx_empty && bus.uart_ready) tx_go = 1'b1;
  end

  // FIFO storage is not reset; pointers and counts define the contents.
  always_ff @(posedge clk) begin
    if (rx_go)   rx_mem[rx_wp] <= bus.uart_din;
    if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_go)   rx_wp <= rx_wp + RX_PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RX_PW'(1);
      if (tx_push) tx_wp <= tx_wp + TX_PW'(1);
      if (tx_go)   tx_rp <= tx_rp + TX_PW'(1);
      unique case ({rx_go, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
        2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      unique case ({tx_push, tx_go})
        2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
        2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // Read mux, registered every cycle from the current decode.
  always_comb begin
    rdata_nxt = '0;
    if (bus.sel) begin
      unique case (bus.addr)
        A_STATUS: rdata_nxt = {4'h0, 4'(rx_cnt), 3'b000, tx_ovf, tx_empty, rx_full,
                               !tx_full, !rx_empty};
        A_RXDATA: if (!rx_empty) rdata_nxt = {8'h00, rx_mem[rx_rp]};
        A_IRQEN:  rdata_nxt = {14'h0000, irqen};
        default:  rdata_nxt = '0;
      endcase
    end
  end

  // Acknowledge is held off until the condition drops or the core services a FIFO.
  always_comb begin
    irq_cond     = (irqen[0] && !rx_empty) || (irqen[1] && tx_empty);
    ack_hold_nxt = ack_hold;
    if (!irq_cond || rx_pop || tx_wr) ack_hold_nxt = 1'b0;
    else if (bus.irqack)              ack_hold_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata     <= '0;
      bus.irq       <= 1'b0;
      bus.uart_rd   <= 1'b0;
      bus.uart_wr   <= 1'b0;
      bus.uart_dout <= '0;
      irqen         <= '0;
      tx_ovf        <= 1'b0;
      ack_hold      <= 1'b0;
    end else begin
      bus.rdata   <= rdata_nxt;
      bus.irq     <= irq_cond && !ack_hold_nxt;
      bus.uart_rd <= rx_go;
      bus.uart_wr <= tx_go;
      if (tx_go) bus.uart_dout <= tx_mem[tx_rp];
      if (irqen_wr) irqen <= bus.wdata[1:0];
      if (tx_wr && tx_full)                tx_ovf <= 1'b1;
      else if (status_wr && bus.wdata[4]) tx_ovf <= 1'b0;
      ack_hold <= ack_hold_nxt;
    end
  end
endmodule

// File: tb/tb_tiny1_uart_mmio.sv
// Scoreboard bench for tiny1_uart_mmio: directed register/RX/TX/IRQ vectors, with a monitor
// that checks rdata and uart_dout against queued expectations.
module tb_tiny1_uart_mmio;
  localparam logic [10:0] A_STATUS = 11'h000;
  localparam logic [10:0] A_RXDATA = 11'h002;
  localparam logic [10:0] A_TXDATA = 11'h004;
  localparam logic [10:0] A_IRQEN  = 11'h006;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tiny1_uart_mmio_if bus();

  tiny1_uart_mmio #(.RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_rd_q[$];
  string       name_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  rx_src[$];

  int cyc = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int last_rd_cyc = -100;
  int last_wr_cyc = -100;
  logic rd_seen = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= bus.sel && bus.rd;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Monitor plus buart model: RX bytes are presented from rx_src and consumed on uart_rd.
  always @(negedge clk) begin
    logic [15:0] e;
    string       n;
    logic [7:0]  t;
    if (!rst) begin
      if (rd_seen) begin
        if (exp_rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rdata_unexpected: got 0x%04h with no expectation queued", bus.rdata);
        end else begin
          e = exp_rd_q.pop_front();
          n = name_rd_q.pop_front();
          check(n, bus.rdata, e);
        end
      end
      if (bus.uart_wr) begin
        if (exp_tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL uart_wr_unexpected: uart_dout 0x%02h with no byte queued", bus.uart_dout);
        end else begin
          t = exp_tx_q.pop_front();
          check("uart_dout", 16'(bus.uart_dout), 16'(t));
        end
        check("uart_wr_spacing_ge3", 16'((cyc - last_wr_cyc) >= 3), 16'd1);
        last_wr_cyc = cyc;
        wr_pulses++;
      end
      if (bus.uart_rd) begin
        check("uart_rd_spacing_ge2", 16'((cyc - last_rd_cyc) >= 2), 16'd1);
        last_rd_cyc = cyc;
        rd_pulses++;
        if (rx_src.size() != 0) void'(rx_src.pop_front());
      end
    end
    bus.uart_valid = (rx_src.size() != 0);
    bus.uart_din   = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [10:0] a, input logic [15:0] e, input string nm);
    @(negedge clk);
    bus.sel  = 1'b1;
    bus.addr = a;
    bus.rd   = 1'b1;
    exp_rd_q.push_back(e);
    name_rd_q.push_back(nm);
    @(negedge clk);
    bus.sel = 1'b0;
    bus.rd  = 1'b0;
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.sel   = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = 1'b1;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.wr  = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.irqack = 1'b1;
    @(negedge clk);
    bus.irqack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int p;
    rst = 1'b1;
    bus.sel = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.irqack = 1'b0; bus.uart_ready = 1'b1;
    cycles(4);
    check("reset_rdata", bus.rdata, 16'h0000);
    check("reset_irq", 16'(bus.irq), 16'd0);
    check("reset_uart_rd", 16'(bus.uart_rd), 16'd0);
    check("reset_uart_wr", 16'(bus.uart_wr), 16'd0);
    check("reset_uart_dout", 16'(bus.uart_dout), 16'h0000);
    rst = 1'b0;

    // Idle status
    bus_read(A_STATUS, 16'h000A, "status_idle");
    cycles(3);
    check("idle_irq", 16'(bus.irq), 16'd0);
    check("idle_no_strobes", 16'(rd_pulses + wr_pulses), 16'd0);

    // Two RX bytes back to back
    rx_src.push_back(8'h41);
    rx_src.push_back(8'h42);
    cycles(10);
    check("rx_two_pulses", 16'(rd_pulses), 16'd2);
    bus_read(A_STATUS, 16'h020B, "status_rx2");
    bus_read(A_RXDATA, 16'h0041, "rxdata_41");
    bus_read(A_RXDATA, 16'h0042, "rxdata_42");
    bus_read(A_RXDATA, 16'h0000, "rxdata_empty");
    bus_read(A_STATUS, 16'h000A, "status_rx_drained");

    // RX fill to full with one byte left pending in buart
    for (int i = 0; i < 9; i++) rx_src.push_back(8'(8'h10 + i));
    cycles(30);
    check("rx_fill_pulses", 16'(rd_pulses), 16'd10);
    check("rx_full_valid_pending", 16'(bus.uart_valid), 16'd1);
    bus_read(A_STATUS, 16'h080F, "status_rx_full");
    p = rd_pulses;
    cycles(5);
    check("rx_full_no_rd", 16'(rd_pulses), 16'(p));
    bus_read(A_RXDATA, 16'h0010, "rxdata_10");
    cycles(3);
    check("rx_refill_one_rd", 16'(rd_pulses), 16'(p + 1));
    cycles(4);
    check("rx_refill_only_one", 16'(rd_pulses), 16'(p + 1));
    for (int i = 1; i < 9; i++) bus_read(A_RXDATA, 16'(16'h0010 + i), "rxdata_drain");
    bus_read(A_STATUS, 16'h000A, "status_after_drain");

    // TX two bytes, then a stalled third
    exp_tx_q.push_back(8'h55);
    exp_tx_q.push_back(8'hAA);
    bus_write(A_TXDATA, 16'h0055);
    bus_write(A_TXDATA, 16'h00AA);
    cycles(10);
    check("tx_two_pulses", 16'(wr_pulses), 16'd2);
    bus.uart_ready = 1'b0;
    exp_tx_q.push_back(8'h66);
    bus_write(A_TXDATA, 16'h0066);
    cycles(8);
    check("tx_stalled", 16'(wr_pulses), 16'd2);
    bus.uart_ready = 1'b1;
    cycles(5);
    check("tx_resumed", 16'(wr_pulses), 16'd3);

    // TX overflow and sticky flag clear
    bus.uart_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_tx_q.push_back(8'(8'h80 + i));
      bus_write(A_TXDATA, 16'(16'h0080 + i));
    end
    bus_read(A_STATUS, 16'h0010, "status_tx_ovf");
    bus_write(A_STATUS, 16'h0010);
    bus_read(A_STATUS, 16'h0000, "status_ovf_cleared");
    bus.uart_ready = 1'b1;
    cycles(40);
    check("tx_burst_pulses", 16'(wr_pulses), 16'd11);
    bus_read(A_STATUS, 16'h000A, "status_tx_drained");

    // IRQ on RX with acknowledge
    bus_write(A_IRQEN, 16'h0001);
    bus_read(A_IRQEN, 16'h0001, "irqen_readback");
    check("irq_rx_empty", 16'(bus.irq), 16'd0);
    rx_src.push_back(8'h5A);
    cycles(5);
    check("irq_rx_raised", 16'(bus.irq), 16'd1);
    pulse_ack();
    check("irq_acked", 16'(bus.irq), 16'd0);
    cycles(4);
    check("irq_ack_held", 16'(bus.irq), 16'd0);
    rx_src.push_back(8'h5B);
    cycles(5);
    check("irq_ack_held_2nd", 16'(bus.irq), 16'd0);
    bus_read(A_STATUS, 16'h020B, "status_irq_rx2");
    check("irq_status_read_no_clear", 16'(bus.irq), 16'd0);
    bus_read(A_RXDATA, 16'h005A, "rxdata_5a");
    check("irq_rearmed_by_pop", 16'(bus.irq), 16'd1);
    bus_read(A_RXDATA, 16'h005B, "rxdata_5b");
    cycles(2);
    check("irq_rx_drained", 16'(bus.irq), 16'd0);

    // IRQ on TX empty, re-armed by a TXDATA push
    bus_write(A_IRQEN, 16'h0002);
    cycles(2);
    check("irq_tx_empty", 16'(bus.irq), 16'd1);
    pulse_ack();
    check("irq_tx_acked", 16'(bus.irq), 16'd0);
    exp_tx_q.push_back(8'h77);
    bus_write(A_TXDATA, 16'h0077);
    cycles(8);
    check("irq_tx_rearmed", 16'(bus.irq), 16'd1);
    bus_write(A_IRQEN, 16'h0000);
    cycles(2);
    check("irq_disabled", 16'(bus.irq), 16'd0);

    // Reset with TX bytes queued discards them
    p = wr_pulses;
    bus.uart_ready = 1'b0;
    bus_write(A_TXDATA, 16'h0099);
    bus_write(A_TXDATA, 16'h009A);
    bus_write(A_IRQEN, 16'h0003);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    bus.uart_ready = 1'b1;
    cycles(10);
    check("reset_discards_tx", 16'(wr_pulses), 16'(p));
    bus_read(A_STATUS, 16'h000A, "status_after_reset");
    bus_read(A_IRQEN, 16'h0000, "irqen_after_reset");
    check("irq_after_reset", 16'(bus.irq), 16'd0);

    for (int i = 0; i < 20; i++) begin
      if (exp_rd_q.size() == 0 && exp_tx_q.size() == 0) break;
      @(negedge clk);
    end
    check("rd_queue_drained", 16'(exp_rd_q.size()), 16'd0);
    check("tx_queue_drained", 16'(exp_tx_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
